// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus between N_MASTERS request/grant/ack masters.
// Grants are registered one-cycle pulses; the owner holds the bus until bus_ack,
// after which priority rotates to the master following the owner.
// Optional feature: define ARB_TIMEOUT_EN to force a release after TIMEOUT_CYCLES
// cycles in the owned state, flagged by a one-cycle timeout_err pulse.
module bus_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         bus_req,
  input  logic                         bus_ack,
  output logic [N_MASTERS-1:0]         bus_grant,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned IdxW = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : gen_param_check
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ArbIdle, ArbGrant, ArbOwned} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                terr_q, terr_d;

  logic                found;
  logic [IdxW-1:0]     winner;
  logic [IdxW-1:0]     cand;
  int unsigned         idx;
  logic [IdxW-1:0]     next_ptr;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
  logic                expired;
`endif

  // Winner search: first requesting master at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx  = (int'(rr_ptr_q) + i) % N_MASTERS;
      cand = IdxW'(idx);
      if (!found && bus_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Pointer after a release: the master just served drops to lowest priority.
  assign next_ptr = (owner_q == IdxW'(N_MASTERS - 1)) ? '0 : owner_q + IdxW'(1);

`ifdef ARB_TIMEOUT_EN
  assign expired = (cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = '0;
    busy_d   = busy_q;
    terr_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ArbIdle: begin
        busy_d = 1'b0;
        if (found) begin
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          busy_d          = 1'b1;
          state_d         = ArbGrant;
        end
      end
      ArbGrant: begin
        // Ack is ignored here: the master has not yet seen its grant.
        state_d = ArbOwned;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ArbOwned: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (bus_ack) begin
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
          state_d  = ArbIdle;
`ifdef ARB_TIMEOUT_EN
        end else if (expired) begin
          busy_d   = 1'b0;
          terr_d   = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = ArbIdle;
`endif
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ArbIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Cycles spent in the owned state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
  logic unused_terr;
  assign unused_terr = terr_q ^ terr_d;
`endif

  assign bus_grant = grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with a grant-order scoreboard.
module tb_bus_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] bus_req;
  logic         bus_ack;
  logic [N-1:0] bus_grant;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;
  int exp_rr   = 0;
  int exp_q[$];

  bus_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .bus_grant   (bus_grant),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] req, input int rr);
    for (int i = 0; i < N; i++) begin
      if (req[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  // Grant must be one-hot-or-zero and never repeat a bit on consecutive cycles.
  logic [N-1:0] prev_grant = '0;
  always @(negedge clk) begin
    check("grant_onehot0", 32'($onehot0(bus_grant)), 32'd1);
    check("grant_no_repeat", 32'(bus_grant & prev_grant), 32'd0);
    prev_grant = bus_grant;
  end

  // Drive a request and wait for the grant pulse; ends in the grant cycle.
  task automatic get_grant(input logic [N-1:0] req, input string tag, output int e);
    int lat;
    bus_req = req;
    exp_q.push_back(model_winner(req, exp_rr));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus_grant == '0 && lat < 10);
    check({tag, "_latency"}, 32'(lat), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check({tag, "_grant"}, 32'(bus_grant), 32'(1 << e));
    check({tag, "_owner"}, 32'(owner), 32'(e));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Full transaction: grant, owned for ack_wait cycles, then one ack pulse.
  task automatic do_txn(input logic [N-1:0] req, input int ack_wait, input bit keep,
                        input string tag);
    int e;
    get_grant(req, tag, e);
    if (!keep) bus_req = '0;
    @(negedge clk);
    check({tag, "_grant_clr"}, 32'(bus_grant), 32'd0);
    check({tag, "_busy_owned"}, 32'(busy), 32'd1);
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      check({tag, "_busy_hold"}, 32'(busy), 32'd1);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check({tag, "_release"}, 32'(busy), 32'd0);
    check({tag, "_owner_kept"}, 32'(owner), 32'(e));
    exp_rr = (e + 1) % N;
  endtask

  initial begin
    int e;
    int n;
    reset   = 1'b0;
    bus_req = '0;
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, timeout_err, owner, bus_grant}, 32'd0);
    reset = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {busy, timeout_err, owner, bus_grant}, 32'd0);
    end

    // All masters requesting continuously: expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 0, 1'b1, "rr_all");
    end
    bus_req = '0;
    @(negedge clk);

    // Single master 2, ack three cycles later; pointer then favours master 3.
    do_txn(4'b0100, 3, 1'b0, "single");
    do_txn(4'b1111, 1, 1'b0, "after_single");

    // Ack in idle and in grant is ignored.
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ack_idle", {busy, bus_grant}, 32'd0);
    get_grant(4'b1000, "ack_grant", e);
    bus_req = '0;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ack_grant_ignored", 32'(busy), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("ack_grant_hold", 32'(busy), 32'd1);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ack_grant_release", 32'(busy), 32'd0);
    exp_rr = (e + 1) % N;

    // Reset two cycles into the owned state with owner 1.
    get_grant(4'b0010, "rst_mid", e);
    bus_req = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rst_async", {busy, timeout_err, owner, bus_grant}, 32'd0);
    exp_rr = 0;
    @(negedge clk);
    reset = 1'b1;
    do_txn(4'b0011, 0, 1'b0, "post_rst");

`ifdef ARB_TIMEOUT_EN
    // No ack: forced release eight cycles after entering the owned state.
    get_grant(4'b0001, "tmo", e);
    bus_req = '0;
    @(negedge clk);
    n = 0;
    while (!timeout_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd8);
    check("tmo_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("tmo_pulse", 32'(timeout_err), 32'd0);
    exp_rr = (e + 1) % N;
`else
    // No ack and no timeout: bus stays owned.
    get_grant(4'b0001, "notmo", e);
    bus_req = '0;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (busy && !timeout_err) n++;
    end
    check("notmo_hold", 32'(n), 32'd120);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("notmo_release", 32'(busy), 32'd0);
    exp_rr = (e + 1) % N;
`endif
    do_txn(4'b1111, 0, 1'b0, "after_tmo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
